digit_scan_driver: RTL and testbench

DIGIT_SCAN_DRIVER -- requirements
Module: digit_scan_driver

---
 rtl/digit_scan_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/digit_scan_driver.sv | 132 +++++++++++++
 tb/tb_digit_scan_driver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/digit_scan_pkg.sv
// rtl/digit_scan_pkg.sv - FSM states, digit count and 7-segment patterns for the digit scan driver.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_M = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int DIGIT_COUNT = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-high 7-segment decode; non-BCD codes go dark.
module seg7_decode
  import digit_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segment
);

  always_comb begin
    segment = SEG_BLANK;
    case (digit)
      4'd0: segment = SEG_0;
      4'd1: segment = SEG_1;
      4'd2: segment = SEG_2;
      4'd3: segment = SEG_3;
      4'd4: segment = SEG_4;
      4'd5: segment = SEG_5;
      4'd6: segment = SEG_6;
      4'd7: segment = SEG_7;
      4'd8: segment = SEG_8;
      4'd9: segment = SEG_9;
      default: segment = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - hh:mm binary-to-BCD converter with multiplexed 4-digit 7-segment scan.
// Optional LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module digit_scan_driver
  import digit_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic       sec_tick,
  output logic       busy,
  output logic [6:0] segment,
  output logic [3:0] digit_en,
  output logic       colon
);

  state_t      state, state_next;
  logic        accept, commit;
  logic [4:0]  work_h;
  logic [5:0]  work_m;
  logic [3:0]  tens_h, tens_m, units_h, units_m;
  logic [3:0]  disp [DIGIT_COUNT];

  logic [15:0] prescale;
  logic        wrap;
  logic [1:0]  index, next_index;
  logic [6:0]  seg_dec, seg_next;

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE:   if (load) begin
                state_next = CONV_H;
                accept     = 1'b1;
              end
      CONV_H: if (work_h < 5'd10) state_next = CONV_M;
      CONV_M: if (work_m < 6'd10) state_next = COMMIT;
      COMMIT: begin
                state_next = IDLE;
                commit     = 1'b1;
              end
      default: state_next = IDLE;
    endcase
  end

  // Repeated subtraction: one tens step per cycle, remainder captured on the exit cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work_h  <= '0;
      work_m  <= '0;
      tens_h  <= '0;
      tens_m  <= '0;
      units_h <= '0;
      units_m <= '0;
      for (int i = 0; i < DIGIT_COUNT; i++) disp[i] <= '0;
    end else begin
      if (accept) begin
        work_h <= hour;
        work_m <= minute;
        tens_h <= '0;
        tens_m <= '0;
      end
      if (state == CONV_H) begin
        if (work_h >= 5'd10) begin
          work_h <= work_h - 5'd10;
          tens_h <= tens_h + 4'd1;
        end else begin
          units_h <= work_h[3:0];
        end
      end
      if (state == CONV_M) begin
        if (work_m >= 6'd10) begin
          work_m <= work_m - 6'd10;
          tens_m <= tens_m + 4'd1;
        end else begin
          units_m <= work_m[3:0];
        end
      end
      if (commit) begin
        disp[0] <= units_m;
        disp[1] <= tens_m;
        disp[2] <= units_h;
        disp[3] <= tens_h;
      end
    end
  end

  assign wrap       = (prescale == 16'(SCAN_DIV - 1));
  assign next_index = wrap ? index + 2'd1 : index;

  seg7_decode u_decode (
    .digit   (disp[next_index]),
    .segment (seg_dec)
  );

  always_comb begin
    seg_next = seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
    if (next_index == 2'd3 && disp[3] == 4'd0) seg_next = SEG_BLANK;
`endif
  end

  // Outputs are registered from next_index so select and pattern switch on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      index    <= '0;
      segment  <= SEG_0;
      digit_en <= 4'b1110;
      colon    <= 1'b0;
    end else begin
      prescale <= wrap ? 16'd0 : prescale + 16'd1;
      index    <= next_index;
      segment  <= seg_next;
      digit_en <= ~(4'b0001 << next_index);
      if (sec_tick) colon <= ~colon;
    end
  end

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb/tb_digit_scan_driver.sv - directed self-checking bench for digit_scan_driver with SCAN_DIV=4.
module tb_digit_scan_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic       sec_tick = 1'b0;
  logic       busy;
  logic [6:0] segment;
  logic [3:0] digit_en;
  logic       colon;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HT0 = 7'h00;
`else
  localparam logic [6:0] HT0 = 7'h3F;
`endif

  logic [3:0] exp_rot [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  digit_scan_driver #(.SCAN_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .hour     (hour),
    .minute   (minute),
    .sec_tick (sec_tick),
    .busy     (busy),
    .segment  (segment),
    .digit_en (digit_en),
    .colon    (colon)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_digit(input int idx, output logic [6:0] seg);
    logic [3:0] pat;
    int n;
    pat = ~(4'b0001 << idx);
    n = 0;
    while (digit_en !== pat && n < 32) begin
      @(negedge clock);
      n++;
    end
    check("scan_reach", 32'(digit_en), 32'(pat));
    seg = segment;
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] s;
    @(negedge clock);
    read_digit(0, s); check({tag, "_d0"}, 32'(s), 32'(e0));
    read_digit(1, s); check({tag, "_d1"}, 32'(s), 32'(e1));
    read_digit(2, s); check({tag, "_d2"}, 32'(s), 32'(e2));
    read_digit(3, s); check({tag, "_d3"}, 32'(s), 32'(e3));
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m);
    hour   = h;
    minute = m;
    load   = 1'b1;
    @(negedge clock);
    load   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(digit_en), 32'(4'b1110));
    check("rst_seg", 32'(segment), 32'h3F);
    check("rst_colon", 32'(colon), 32'd0);

    reset = 1'b1;
    check("rel_en", 32'(digit_en), 32'(4'b1110));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k % 4 == 0) check("rot_en", 32'(digit_en), 32'(exp_rot[k / 4 - 1]));
      if (k == 12) check("rot_seg_ht", 32'(segment), 32'(HT0));
    end

    do_load(5'd0, 6'd0);
    count_busy(n);
    check("lat_0000", 32'(n), 32'd3);

    do_load(5'd23, 6'd59);
    count_busy(n);
    check("lat_2359", 32'(n), 32'd10);
    check_digits("d2359", 7'h6F, 7'h6D, 7'h4F, 7'h5B);

    do_load(5'd12, 6'd34);
    @(negedge clock);
    check("busy_c2", 32'(busy), 32'd1);
    hour   = 5'd5;
    minute = 6'd0;
    load   = 1'b1;
    @(negedge clock);
    load   = 1'b0;
    count_busy(n);
    check("lat_1234_rest", 32'(n), 32'd5);
    @(negedge clock);
    check("no_queue", 32'(busy), 32'd0);
    check_digits("d1234", 7'h66, 7'h4F, 7'h5B, 7'h06);

    do_load(5'd7, 6'd0);
    count_busy(n);
    check("lat_0700", 32'(n), 32'd3);
    check_digits("d0700", 7'h3F, 7'h3F, 7'h07, HT0);

    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    do_load(5'd23, 6'd59);
    repeat (4) @(negedge clock);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_en", 32'(digit_en), 32'(4'b1110));
    check("mid_rst_seg", 32'(segment), 32'h3F);
    @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    check("mid_idle", 32'(busy), 32'd0);
    check_digits("dmid", 7'h3F, 7'h3F, 7'h3F, HT0);

    check("colon0", 32'(colon), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sec_tick = 1'b1;
      @(negedge clock);
      sec_tick = 1'b0;
      check("colon_tick", 32'(colon), 32'(i % 2 == 0));
    end
    @(negedge clock);
    check("colon_hold", 32'(colon), 32'd1);

    do_load(5'd31, 6'd63);
    count_busy(n);
    check("lat_3163", 32'(n), 32'd12);
    check_digits("d3163", 7'h4F, 7'h7D, 7'h06, 7'h4F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
